// File: rtl/reorder_buffer.sv
// reorder_buffer
// In-order retirement buffer for a dual-issue core. Up to two renamed
// instructions enter per cycle at the tail. Completion is reported out of
// order through two writeback ports. Up to two completed instructions
// retire per cycle from the head, in program order.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   disp_*_0 / disp_*_1       dispatch slots (slot 1 is the younger one)
//   disp_ready_0/1            slot accepted when its valid is high
//   disp_idx_0/1              ROB index assigned to each slot
//   wb_valid_0/1, wb_idx_0/1  completion reports
//   flush                     discard every in-flight entry
//   commit_*_0/1              retiring entry (committed RAT update)
//   free_valid_0/1, free_preg_0/1  previous mapping of rd to release
//   rob_count, rob_empty, rob_full  occupancy status
`timescale 1ns/1ps
module reorder_buffer #(
  parameter int DEPTH     = 16,
  parameter int IDX_WIDTH = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_valid_0,
  input  logic                 disp_has_rd_0,
  input  logic [4:0]           disp_rd_0,
  input  logic [TAG_WIDTH-1:0] disp_preg_0,
  input  logic [TAG_WIDTH-1:0] disp_old_preg_0,
  input  logic                 disp_valid_1,
  input  logic                 disp_has_rd_1,
  input  logic [4:0]           disp_rd_1,
  input  logic [TAG_WIDTH-1:0] disp_preg_1,
  input  logic [TAG_WIDTH-1:0] disp_old_preg_1,
  output logic                 disp_ready_0,
  output logic                 disp_ready_1,
  output logic [IDX_WIDTH-1:0] disp_idx_0,
  output logic [IDX_WIDTH-1:0] disp_idx_1,
  input  logic                 wb_valid_0,
  input  logic                 wb_valid_1,
  input  logic [IDX_WIDTH-1:0] wb_idx_0,
  input  logic [IDX_WIDTH-1:0] wb_idx_1,
  input  logic                 flush,
  output logic                 commit_valid_0,
  output logic                 commit_valid_1,
  output logic [4:0]           commit_rd_0,
  output logic [4:0]           commit_rd_1,
  output logic [TAG_WIDTH-1:0] commit_preg_0,
  output logic [TAG_WIDTH-1:0] commit_preg_1,
  output logic                 free_valid_0,
  output logic                 free_valid_1,
  output logic [TAG_WIDTH-1:0] free_preg_0,
  output logic [TAG_WIDTH-1:0] free_preg_1,
  output logic [IDX_WIDTH:0]   rob_count,
  output logic                 rob_empty,
  output logic                 rob_full
);

  localparam logic [IDX_WIDTH:0] L_DEPTH = (IDX_WIDTH+1)'(DEPTH);
  localparam logic [IDX_WIDTH:0] L_LIM0  = (IDX_WIDTH+1)'(DEPTH - 1);
  localparam logic [IDX_WIDTH:0] L_LIM1  = (IDX_WIDTH+1)'(DEPTH - 2);

  // Control state
  logic [IDX_WIDTH-1:0] r_head;
  logic [IDX_WIDTH-1:0] r_tail;
  logic [IDX_WIDTH:0]   r_count;
  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_done;

  // Entry payload (not reset; only meaningful while valid is set)
  logic [DEPTH-1:0]     r_has_rd;
  logic [4:0]           r_rd       [DEPTH];
  logic [TAG_WIDTH-1:0] r_preg     [DEPTH];
  logic [TAG_WIDTH-1:0] r_old_preg [DEPTH];

  logic [IDX_WIDTH-1:0] w_head1;
  logic [IDX_WIDTH-1:0] w_tail1;
  logic                 w_acc_0;
  logic                 w_acc_1;
  logic [1:0]           w_n_acc;
  logic [1:0]           w_n_com;

  // DEPTH is a power of two, so natural IDX_WIDTH overflow is the wrap.
  assign w_head1 = r_head + IDX_WIDTH'(1);
  assign w_tail1 = r_tail + IDX_WIDTH'(1);

  // Readiness looks only at the registered count; space released by a
  // same-cycle commit is not reused, so the tail never lands on the head.
  assign disp_ready_0 = (r_count <= L_LIM0);
  assign disp_ready_1 = disp_valid_0 && (r_count <= L_LIM1);
  assign disp_idx_0   = r_tail;
  assign disp_idx_1   = w_tail1;

  assign w_acc_0 = disp_valid_0 && disp_ready_0 && !flush;
  assign w_acc_1 = disp_valid_1 && disp_ready_1 && !flush;
  assign w_n_acc = w_acc_1 ? 2'd2 : (w_acc_0 ? 2'd1 : 2'd0);

  assign commit_valid_0 = r_valid[r_head] && r_done[r_head] && !flush;
  assign commit_valid_1 = commit_valid_0 && r_valid[w_head1] && r_done[w_head1];
  assign w_n_com = commit_valid_1 ? 2'd2 : (commit_valid_0 ? 2'd1 : 2'd0);

  assign commit_rd_0   = r_has_rd[r_head]  ? r_rd[r_head]  : 5'd0;
  assign commit_rd_1   = r_has_rd[w_head1] ? r_rd[w_head1] : 5'd0;
  assign commit_preg_0 = r_preg[r_head];
  assign commit_preg_1 = r_preg[w_head1];

  // x0 has no rename mapping, so nothing is released for it.
  assign free_valid_0 = commit_valid_0 && r_has_rd[r_head]  && (r_rd[r_head]  != 5'd0);
  assign free_valid_1 = commit_valid_1 && r_has_rd[w_head1] && (r_rd[w_head1] != 5'd0);
  assign free_preg_0  = r_old_preg[r_head];
  assign free_preg_1  = r_old_preg[w_head1];

  assign rob_count = r_count;
  assign rob_empty = (r_count == '0);
  assign rob_full  = (r_count == L_DEPTH);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      // Later assignments win: writeback, then commit clear, then dispatch.
      if (wb_valid_0 && r_valid[wb_idx_0]) r_done[wb_idx_0] <= 1'b1;
      if (wb_valid_1 && r_valid[wb_idx_1]) r_done[wb_idx_1] <= 1'b1;
      if (commit_valid_0) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
      end
      if (commit_valid_1) begin
        r_valid[w_head1] <= 1'b0;
        r_done[w_head1]  <= 1'b0;
      end
      if (w_acc_0) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
      end
      if (w_acc_1) begin
        r_valid[w_tail1] <= 1'b1;
        r_done[w_tail1]  <= 1'b0;
      end
      r_head  <= r_head + {{(IDX_WIDTH-2){1'b0}}, w_n_com};
      r_tail  <= r_tail + {{(IDX_WIDTH-2){1'b0}}, w_n_acc};
      r_count <= r_count + {{(IDX_WIDTH-1){1'b0}}, w_n_acc}
                         - {{(IDX_WIDTH-1){1'b0}}, w_n_com};
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc_0) begin
      r_has_rd[r_tail]   <= disp_has_rd_0;
      r_rd[r_tail]       <= disp_rd_0;
      r_preg[r_tail]     <= disp_preg_0;
      r_old_preg[r_tail] <= disp_old_preg_0;
    end
    if (w_acc_1) begin
      r_has_rd[w_tail1]   <= disp_has_rd_1;
      r_rd[w_tail1]       <= disp_rd_1;
      r_preg[w_tail1]     <= disp_preg_1;
      r_old_preg[w_tail1] <= disp_old_preg_1;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int TAG_W = 6;

  logic clk = 1'b0;
  logic rst;
  logic disp_valid_0, disp_has_rd_0, disp_valid_1, disp_has_rd_1;
  logic [4:0] disp_rd_0, disp_rd_1;
  logic [TAG_W-1:0] disp_preg_0, disp_old_preg_0, disp_preg_1, disp_old_preg_1;
  logic disp_ready_0, disp_ready_1;
  logic [IDX_W-1:0] disp_idx_0, disp_idx_1;
  logic wb_valid_0, wb_valid_1;
  logic [IDX_W-1:0] wb_idx_0, wb_idx_1;
  logic flush;
  logic commit_valid_0, commit_valid_1;
  logic [4:0] commit_rd_0, commit_rd_1;
  logic [TAG_W-1:0] commit_preg_0, commit_preg_1;
  logic free_valid_0, free_valid_1;
  logic [TAG_W-1:0] free_preg_0, free_preg_1;
  logic [IDX_W:0] rob_count;
  logic rob_empty, rob_full;

  reorder_buffer #(.DEPTH(DEPTH), .IDX_WIDTH(IDX_W), .TAG_WIDTH(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .disp_valid_0(disp_valid_0), .disp_has_rd_0(disp_has_rd_0), .disp_rd_0(disp_rd_0),
    .disp_preg_0(disp_preg_0), .disp_old_preg_0(disp_old_preg_0),
    .disp_valid_1(disp_valid_1), .disp_has_rd_1(disp_has_rd_1), .disp_rd_1(disp_rd_1),
    .disp_preg_1(disp_preg_1), .disp_old_preg_1(disp_old_preg_1),
    .disp_ready_0(disp_ready_0), .disp_ready_1(disp_ready_1),
    .disp_idx_0(disp_idx_0), .disp_idx_1(disp_idx_1),
    .wb_valid_0(wb_valid_0), .wb_valid_1(wb_valid_1),
    .wb_idx_0(wb_idx_0), .wb_idx_1(wb_idx_1), .flush(flush),
    .commit_valid_0(commit_valid_0), .commit_valid_1(commit_valid_1),
    .commit_rd_0(commit_rd_0), .commit_rd_1(commit_rd_1),
    .commit_preg_0(commit_preg_0), .commit_preg_1(commit_preg_1),
    .free_valid_0(free_valid_0), .free_valid_1(free_valid_1),
    .free_preg_0(free_preg_0), .free_preg_1(free_preg_1),
    .rob_count(rob_count), .rob_empty(rob_empty), .rob_full(rob_full)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered queue of in-flight instructions.
  typedef struct {
    int idx;
    bit has_rd;
    int rd;
    int preg;
    int old;
    bit done;
  } ent_t;

  ent_t q[$];
  int   m_tail;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sz;
    bit e_cv0, e_cv1, e_fv0, e_fv1;
    sz = q.size();
    e_cv0 = 0; e_cv1 = 0; e_fv0 = 0; e_fv1 = 0;
    if (sz > 0 && !flush) e_cv0 = q[0].done;
    if (e_cv0 && sz > 1) e_cv1 = q[1].done;
    if (e_cv0) e_fv0 = q[0].has_rd && q[0].rd != 0;
    if (e_cv1) e_fv1 = q[1].has_rd && q[1].rd != 0;
    chk("rob_count", 32'(rob_count), sz);
    chk("rob_empty", 32'(rob_empty), 32'(sz == 0));
    chk("rob_full", 32'(rob_full), 32'(sz == DEPTH));
    chk("disp_ready_0", 32'(disp_ready_0), 32'(sz <= DEPTH - 1));
    chk("disp_ready_1", 32'(disp_ready_1), 32'(disp_valid_0 && sz <= DEPTH - 2));
    chk("disp_idx_0", 32'(disp_idx_0), m_tail);
    chk("disp_idx_1", 32'(disp_idx_1), (m_tail + 1) % DEPTH);
    chk("commit_valid_0", 32'(commit_valid_0), 32'(e_cv0));
    chk("commit_valid_1", 32'(commit_valid_1), 32'(e_cv1));
    chk("free_valid_0", 32'(free_valid_0), 32'(e_fv0));
    chk("free_valid_1", 32'(free_valid_1), 32'(e_fv1));
    if (e_cv0) begin
      chk("commit_rd_0", 32'(commit_rd_0), q[0].has_rd ? q[0].rd : 0);
      chk("commit_preg_0", 32'(commit_preg_0), q[0].preg);
    end
    if (e_cv1) begin
      chk("commit_rd_1", 32'(commit_rd_1), q[1].has_rd ? q[1].rd : 0);
      chk("commit_preg_1", 32'(commit_preg_1), q[1].preg);
    end
    if (e_fv0) chk("free_preg_0", 32'(free_preg_0), q[0].old);
    if (e_fv1) chk("free_preg_1", 32'(free_preg_1), q[1].old);
  endtask

  task automatic model_edge();
    int  sz, ncom;
    bit  a0, a1;
    ent_t e;
    if (rst || flush) begin
      q.delete();
      m_tail = 0;
      return;
    end
    sz = q.size();
    ncom = 0;
    if (sz > 0 && q[0].done) begin
      ncom = 1;
      if (sz > 1 && q[1].done) ncom = 2;
    end
    a0 = disp_valid_0 && sz <= DEPTH - 1;
    a1 = disp_valid_1 && disp_valid_0 && sz <= DEPTH - 2;
    foreach (q[i]) begin
      if (wb_valid_0 && q[i].idx == int'(wb_idx_0)) q[i].done = 1;
      if (wb_valid_1 && q[i].idx == int'(wb_idx_1)) q[i].done = 1;
    end
    for (int k = 0; k < ncom; k++) void'(q.pop_front());
    if (a0) begin
      e = '{idx: m_tail, has_rd: disp_has_rd_0, rd: int'(disp_rd_0),
            preg: int'(disp_preg_0), old: int'(disp_old_preg_0), done: 0};
      q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
    if (a1) begin
      e = '{idx: m_tail, has_rd: disp_has_rd_1, rd: int'(disp_rd_1),
            preg: int'(disp_preg_1), old: int'(disp_old_preg_1), done: 0};
      q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    disp_valid_0 = 0; disp_has_rd_0 = 0; disp_rd_0 = '0; disp_preg_0 = '0; disp_old_preg_0 = '0;
    disp_valid_1 = 0; disp_has_rd_1 = 0; disp_rd_1 = '0; disp_preg_1 = '0; disp_old_preg_1 = '0;
    wb_valid_0 = 0; wb_valid_1 = 0; wb_idx_0 = '0; wb_idx_1 = '0;
    flush = 0;
  endtask

  task automatic set_d0(input bit h, input int rd, input int p, input int o);
    disp_valid_0 = 1; disp_has_rd_0 = h; disp_rd_0 = 5'(rd);
    disp_preg_0 = TAG_W'(p); disp_old_preg_0 = TAG_W'(o);
  endtask

  task automatic set_d1(input bit h, input int rd, input int p, input int o);
    disp_valid_1 = 1; disp_has_rd_1 = h; disp_rd_1 = 5'(rd);
    disp_preg_1 = TAG_W'(p); disp_old_preg_1 = TAG_W'(o);
  endtask

  task automatic set_wb(input bit v0, input int i0, input bit v1, input int i1);
    wb_valid_0 = v0; wb_idx_0 = IDX_W'(i0);
    wb_valid_1 = v1; wb_idx_1 = IDX_W'(i1);
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    @(posedge clk);
    model_edge();
    #1;
    tick();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle();
    q.delete();
    m_tail = 0;

    // Reset then idle
    do_reset();
    tick();
    chk("reset_empty", 32'(rob_empty), 1);
    chk("reset_ready0", 32'(disp_ready_0), 1);

    // Single dispatch, writeback, commit
    set_d0(1, 5, 33, 5);
    tick();
    idle();
    set_wb(1, 0, 0, 0);
    tick();
    idle();
    #1;
    chk("single_commit_rd", 32'(commit_rd_0), 5);
    chk("single_commit_preg", 32'(commit_preg_0), 33);
    chk("single_free_preg", 32'(free_preg_0), 5);
    tick();
    tick();

    // Dual dispatch; younger completes first
    do_reset();
    set_d0(1, 3, 40, 7);
    set_d1(1, 0, 41, 8);
    tick();
    idle();
    set_wb(1, 1, 0, 0);
    tick();
    idle();
    tick();
    set_wb(1, 0, 0, 0);
    tick();
    idle();
    #1;
    chk("dual_cv0", 32'(commit_valid_0), 1);
    chk("dual_cv1", 32'(commit_valid_1), 1);
    chk("dual_rd1", 32'(commit_rd_1), 0);
    chk("dual_fv1", 32'(free_valid_1), 0);
    tick();
    tick();

    // Fill to capacity
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_d0(1, k + 1, 2 * k, 50);
      set_d1(1, k + 9, 2 * k + 1, 51);
      tick();
      idle();
    end
    set_d0(1, 20, 14, 52);
    tick();
    set_d0(1, 21, 15, 53);
    set_d1(1, 22, 16, 54);
    #1;
    chk("fill_ready1_at15", 32'(disp_ready_1), 0);
    tick();
    idle();
    #1;
    chk("fill_full", 32'(rob_full), 1);
    chk("fill_ready0", 32'(disp_ready_0), 0);
    chk("fill_count", 32'(rob_count), 16);
    set_d0(1, 23, 17, 55);
    tick();
    idle();

    // Drain entries 0..14 so head sits at 15, then wrap
    for (int k = 0; k < 7; k++) begin
      set_wb(1, 2 * k, 1, 2 * k + 1);
      tick();
    end
    set_wb(1, 14, 0, 0);
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();
    chk("wrap_count1", 32'(rob_count), 1);
    set_d0(1, 9, 60, 61);
    tick();
    idle();
    set_wb(1, 15, 1, 0);
    tick();
    idle();
    #1;
    chk("wrap_cv0", 32'(commit_valid_0), 1);
    chk("wrap_cv1", 32'(commit_valid_1), 1);
    chk("wrap_preg1", 32'(commit_preg_1), 60);
    tick();
    set_d0(1, 1, 2, 3);
    #1;
    chk("wrap_head_idx", 32'(disp_idx_0), 1);
    tick();
    idle();

    // Flush with six entries, three done, and a dispatch in the same cycle
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_d0(1, k + 1, 10 + k, 20 + k);
      set_d1(1, k + 4, 30 + k, 40 + k);
      tick();
      idle();
    end
    set_wb(1, 3, 1, 5);
    tick();
    idle();
    set_wb(1, 0, 0, 0);
    tick();
    idle();
    flush = 1;
    set_d0(1, 7, 7, 7);
    set_wb(1, 1, 0, 0);
    #1;
    chk("flush_cv0", 32'(commit_valid_0), 0);
    chk("flush_cv1", 32'(commit_valid_1), 0);
    tick();
    idle();
    #1;
    chk("flush_count", 32'(rob_count), 0);
    chk("flush_empty", 32'(rob_empty), 1);
    chk("flush_idx0", 32'(disp_idx_0), 0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 2) != 0)
        set_d0($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0)
        set_d1($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      for (int p = 0; p < 2; p++) begin
        int ix;
        bit v;
        v = ($urandom_range(0, 3) != 0);
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          ix = q[$urandom_range(0, q.size() - 1)].idx;
        else
          ix = $urandom_range(0, DEPTH - 1);
        if (p == 0) begin wb_valid_0 = v; wb_idx_0 = IDX_W'(ix); end
        else        begin wb_valid_1 = v; wb_idx_1 = IDX_W'(ix); end
      end
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer for the dual-issue core; sits between rename/dispatch and the register rename unit's commit/free inputs.
- Accepts up to 2 renamed instructions per cycle and records completion from the execution units out of order.
- Retires up to 2 completed instructions per cycle in program order, driving committed-RAT updates and physical-register frees (the previous mapping of rd).

Parameters:
DEPTH, 16, number of ROB entries; power of two, >= 4
IDX_WIDTH, 4, log2(DEPTH)
TAG_WIDTH, 6, physical register tag width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
disp_valid_0  input  1  dispatch slot 0 request
disp_has_rd_0  input  1  slot 0 writes a destination
disp_rd_0  input  5  slot 0 architectural rd
disp_preg_0  input  TAG_WIDTH  slot 0 newly allocated physical rd
disp_old_preg_0  input  TAG_WIDTH  slot 0 previous mapping of rd, freed at commit
disp_valid_1, disp_has_rd_1, disp_rd_1, disp_preg_1, disp_old_preg_1  input  as slot 0  dispatch slot 1 (younger)
disp_ready_0  output  1  slot 0 accepted when disp_valid_0 is high
disp_ready_1  output  1  slot 1 accepted when disp_valid_1 is high
disp_idx_0, disp_idx_1  output  IDX_WIDTH  ROB index assigned to each slot
wb_valid_0, wb_valid_1  input  1  completion reports
wb_idx_0, wb_idx_1  input  IDX_WIDTH  completing entry index
flush  input  1  discard all in-flight entries
commit_valid_0, commit_valid_1  output  1  entry retiring this cycle
commit_rd_0, commit_rd_1  output  5  retiring arch rd
commit_preg_0, commit_preg_1  output  TAG_WIDTH  retiring phys rd
free_valid_0, free_valid_1  output  1  free old preg
free_preg_0, free_preg_1  output  TAG_WIDTH  preg being freed
rob_count  output  IDX_WIDTH+1  occupied entries
rob_empty, rob_full  output  1  status

Behaviour:
- Reset (synchronous, active-high): head=tail=count=0; all entry valid/done bits 0; all commit_valid/free_valid 0; rob_empty=1; rob_full=0; rob_count=0. Reset overrides everything else in the same cycle.
- Entry fields: valid, done, has_rd, rd, preg, old_preg.
- Dispatch ready (from registered count only; same-cycle commits do not free space):
  - disp_ready_0 = (count <= DEPTH-1).
  - disp_ready_1 = disp_valid_0 && (count <= DEPTH-2).
- Slot 1 is never accepted without slot 0. disp_valid_1 alone is ignored.
- disp_idx_0 = tail; disp_idx_1 = tail+1 mod DEPTH.
- On accept: write the entry with valid=1, done=0; tail advances by the number accepted (0/1/2), wrapping mod DEPTH.
- Writeback: wb_valid_x sets done[wb_idx_x] at the clock edge. Writebacks to entries with valid=0 are ignored. Both ports may target any entries. done is visible to commit the cycle after writeback (no same-cycle bypass).
- Commit outputs are combinational from registered state only:
  - commit_valid_0 = valid[head] && done[head] && !flush.
  - commit_valid_1 = commit_valid_0 && valid[head+1] && done[head+1].
  - commit_rd/preg come from the entry; commit_rd is forced to 0 when has_rd=0.
  - free_valid_x = commit_valid_x && has_rd && rd != 0; free_preg_x = old_preg.
- At the edge: committed entries clear valid/done; head advances by 0/1/2 mod DEPTH.
- count_next = count + accepted - committed. Dispatch and commit in the same cycle are legal. The dispatch write to a new tail and the commit clear of the head never conflict because dispatch readiness excludes same-cycle frees.
- rob_full = (count == DEPTH); rob_empty = (count == 0).
- Flush (synchronous): head=tail=count=0; all valid/done cleared. The same-cycle dispatch and writeback are dropped. Commit/free outputs are forced 0 during the flush cycle. Recovery of the speculative RAT is external.
- Wrap-around: head+1 and tail+1 computed mod DEPTH; the slot 1 commit across the wrap boundary is legal.

Test Plan:
- Reset, then idle: rob_empty=1, rob_count=0, disp_ready_0=1, all commit_valid/free_valid=0.
- Dispatch slot 0 (rd=5, preg=33, old=5) at idx 0; wb idx 0 next cycle -> the following cycle commit_valid_0=1, commit_rd_0=5, commit_preg_0=33, free_valid_0=1, free_preg_0=5; rob_empty returns to 1.
- Dual dispatch: idx0 (rd=3, preg=40) and idx1 (rd=0); wb idx1 first, then idx0 -> no commit after idx1 wb alone. After idx0 wb: commit_valid_0=1 and commit_valid_1=1 together; commit_rd_1=0, free_valid_1=0.
- Fill 16 entries with no wb -> rob_full=1, disp_ready_0=0. Dual dispatch attempted at count=15 -> only slot 0 accepted, disp_ready_1=0, count=16.
- Wrap: cycle so head=15 and tail=1 with entries 15 and 0 done -> both commit in one cycle; head becomes 1.
- Flush with 6 entries, 3 done, plus a simultaneous dispatch -> commit_valid_x=0 that cycle. Next cycle rob_count=0, rob_empty=1, disp_idx_0=0.
